// File: rtl/dma_mem_pkg.sv
// rtl/dma_mem_pkg.sv - shared state encoding, mode values and LFSR taps for dma_mem_port
package dma_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    localparam logic MODE_CPU_TO_MEM = 1'b1;
    localparam logic MODE_MEM_TO_CPU = 1'b0;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/dma_mem_port_if.sv
// rtl/dma_mem_port_if.sv - command and nibble handshake bundle between DMA engine and memory port
interface dma_mem_port_if;

    logic        mode;
    logic        addr_in_valid;
    logic        addr_in_enable;
    logic [31:0] addr_in;
    logic [31:0] len_in;
    logic        dma_to_mem_valid;
    logic        dma_to_mem_enable;
    logic [3:0]  mem_in_socket;
    logic        mem_to_dma_enable;
    logic        mem_to_dma_valid;
    logic [3:0]  mem_out_socket;
    logic        xfer_done;

    modport master (
        output mode, addr_in_valid, addr_in, len_in,
        output dma_to_mem_valid, mem_in_socket, mem_to_dma_enable,
        input  addr_in_enable, dma_to_mem_enable, mem_to_dma_valid,
        input  mem_out_socket, xfer_done
    );

    modport slave (
        input  mode, addr_in_valid, addr_in, len_in,
        input  dma_to_mem_valid, mem_in_socket, mem_to_dma_enable,
        output addr_in_enable, dma_to_mem_enable, mem_to_dma_valid,
        output mem_out_socket, xfer_done
    );

endinterface

// File: rtl/dma_mem_ram.sv
// rtl/dma_mem_ram.sv - unreset byte array, one synchronous write port, datapath and debug read ports
module dma_mem_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data  = mem[rd_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/dma_mem_port.sv
// rtl/dma_mem_port.sv - DMA memory endpoint moving bytes as low-first nibbles; MEM_STALL_EN adds LFSR stalls
module dma_mem_port
    import dma_mem_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic               clk,
    input  logic               resetn,
    dma_mem_port_if.slave      bus,
    input  logic [ADDR_W-1:0]  dbg_addr,
    output logic [7:0]         dbg_data
);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_inc;
    logic [ADDR_W-1:0] rd_idx;
    logic [31:0]       remaining;
    logic              flag;
    logic [3:0]        byte_lo;
    logic [3:0]        hi_nib;
    logic [7:0]        rd_data;
    logic              cmd_fire;
    logic              wr_fire;
    logic              rd_fire;
    logic              wr_en;
    logic              ready_nxt;
    logic              unused_addr;

    assign cmd_fire = bus.addr_in_valid & bus.addr_in_enable;
    assign wr_fire  = bus.dma_to_mem_valid & bus.dma_to_mem_enable;
    assign rd_fire  = bus.mem_to_dma_valid & bus.mem_to_dma_enable;
    assign ptr_inc  = ptr + ADDR_W'(1);
    assign wr_en    = (state == WR) && wr_fire && flag;
    assign unused_addr = ^bus.addr_in[31:ADDR_W];

    // Prefetch address: the command's start byte while idle, otherwise the byte after ptr
    assign rd_idx = (state == IDLE) ? bus.addr_in[ADDR_W-1:0] : ptr_inc;

`ifdef MEM_STALL_EN
    logic [7:0] lfsr;
    logic [7:0] lfsr_nxt;

    assign lfsr_nxt  = {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    assign ready_nxt = lfsr_nxt[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_nxt;
        end
    end
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign ready_nxt   = 1'b1;
`endif

    dma_mem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_addr  (ptr),
        .wr_data  ({bus.mem_in_socket, byte_lo}),
        .rd_addr  (rd_idx),
        .rd_data  (rd_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state                 <= IDLE;
            ptr                   <= '0;
            remaining             <= '0;
            flag                  <= 1'b0;
            byte_lo               <= '0;
            hi_nib                <= '0;
            bus.addr_in_enable    <= 1'b0;
            bus.dma_to_mem_enable <= 1'b0;
            bus.mem_to_dma_valid  <= 1'b0;
            bus.mem_out_socket    <= '0;
            bus.xfer_done         <= 1'b0;
        end else begin
            bus.xfer_done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.addr_in_enable    <= 1'b1;
                    bus.dma_to_mem_enable <= 1'b0;
                    bus.mem_to_dma_valid  <= 1'b0;
                    if (cmd_fire) begin
                        ptr       <= bus.addr_in[ADDR_W-1:0];
                        remaining <= bus.len_in;
                        flag      <= 1'b0;
                        if (bus.len_in == 32'd0) begin
                            bus.xfer_done <= 1'b1;
                        end else if (bus.mode == MODE_CPU_TO_MEM) begin
                            state                 <= WR;
                            bus.addr_in_enable    <= 1'b0;
                            bus.dma_to_mem_enable <= ready_nxt;
                        end else begin
                            state                <= RD;
                            bus.addr_in_enable   <= 1'b0;
                            bus.mem_to_dma_valid <= ready_nxt;
                            bus.mem_out_socket   <= rd_data[3:0];
                            hi_nib               <= rd_data[7:4];
                        end
                    end
                end
                WR: begin
                    bus.dma_to_mem_enable <= ready_nxt;
                    if (wr_fire) begin
                        if (!flag) begin
                            byte_lo <= bus.mem_in_socket;
                            flag    <= 1'b1;
                        end else begin
                            flag      <= 1'b0;
                            ptr       <= ptr_inc;
                            remaining <= remaining - 32'd1;
                            if (remaining == 32'd1) begin
                                state                 <= IDLE;
                                bus.dma_to_mem_enable <= 1'b0;
                                bus.addr_in_enable    <= 1'b1;
                                bus.xfer_done         <= 1'b1;
                            end
                        end
                    end
                end
                RD: begin
                    bus.mem_to_dma_valid <= ready_nxt;
                    if (rd_fire) begin
                        if (!flag) begin
                            bus.mem_out_socket <= hi_nib;
                            flag               <= 1'b1;
                        end else begin
                            flag      <= 1'b0;
                            ptr       <= ptr_inc;
                            remaining <= remaining - 32'd1;
                            if (remaining == 32'd1) begin
                                state                <= IDLE;
                                bus.mem_to_dma_valid <= 1'b0;
                                bus.addr_in_enable   <= 1'b1;
                                bus.xfer_done        <= 1'b1;
                            end else begin
                                bus.mem_out_socket <= rd_data[3:0];
                                hi_nib             <= rd_data[7:4];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
